// File: rtl/vedic_mul_pipe_pkg.sv
// vedic_mul_pipe_pkg: shared multiplier constants (legal widths, pipeline depth)
package vedic_mul_pipe_pkg;
  localparam int STAGES = 2;
  localparam int N_LEGAL = 4;
  localparam int LEGAL_W [N_LEGAL] = '{8, 16, 32, 64};
  function automatic bit legal_w(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL; i++) ok |= (LEGAL_W[i] == w);
    return ok;
  endfunction
endpackage

// File: rtl/vedic_mul_pipe_tile.sv
// vedic_tile: combinational N x N unsigned vedic multiplier, recursive down to 8x8 tiles
import vedic_mul_pipe_pkg::*;
module vedic_tile #(
  parameter int N = 8
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  if (N <= 8) begin : g_leaf
    assign p = (2*N)'(a) * (2*N)'(b);
  end else begin : g_rec
    localparam int H = N / 2;
    logic [N-1:0]   ll, lh, hl, hh;
    logic [2*N-1:0] mid;
    vedic_tile #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
    vedic_tile #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
    vedic_tile #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
    vedic_tile #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));
    assign mid = (2*N)'(lh) + (2*N)'(hl);
    assign p   = {hh, ll} + (mid << H);
  end
endmodule

// File: rtl/vedic_mul_pipe.sv
// vedic_mul_pipe: two-stage valid/ready signed/unsigned vedic multiplier
import vedic_mul_pipe_pkg::*;
module vedic_mul_pipe #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);
  localparam int H = W / 2;
  if (!legal_w(W)) begin : g_bad_w
    $error("vedic_mul_pipe: illegal W");
  end
  logic           v1, v2, ld1, ld2, neg1;
  logic [W-1:0]   am, bm, ll, lh, hl, hh;
  logic [W-1:0]   pp_ll, pp_lh, pp_hl, pp_hh;
  logic [2*W-1:0] mid, sum;
  assign ld2       = !v2 | out_ready;
  assign ld1       = !v1 | ld2;
  assign in_ready  = ld1;
  assign out_valid = v2;
  // -2^(W-1) negates to itself, which is the correct unsigned magnitude
  assign am = (sgn & a[W-1]) ? -a : a;
  assign bm = (sgn & b[W-1]) ? -b : b;
  vedic_tile #(.N(H)) u_ll (.a(am[H-1:0]), .b(bm[H-1:0]), .p(ll));
  vedic_tile #(.N(H)) u_lh (.a(am[H-1:0]), .b(bm[W-1:H]), .p(lh));
  vedic_tile #(.N(H)) u_hl (.a(am[W-1:H]), .b(bm[H-1:0]), .p(hl));
  vedic_tile #(.N(H)) u_hh (.a(am[W-1:H]), .b(bm[W-1:H]), .p(hh));
  assign mid = (2*W)'(pp_hl) + (2*W)'(pp_lh);
  assign sum = {pp_hh, pp_ll} + (mid << H);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      neg1  <= 1'b0;
      pp_ll <= '0;
      pp_lh <= '0;
      pp_hl <= '0;
      pp_hh <= '0;
      p     <= '0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld1 & in_valid) begin
        pp_ll <= ll;
        pp_lh <= lh;
        pp_hl <= hl;
        pp_hh <= hh;
        neg1  <= sgn & (a[W-1] ^ b[W-1]);
      end
      if (ld2 & v1) p <= neg1 ? -sum : sum;
    end
  end
endmodule

// File: tb/tb_vedic_mul_pipe.sv
// tb_vedic_mul_pipe: directed W=16 scenarios plus W=8/32/64 random regressions
module tb_vedic_mul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  logic        iv = 1'b0, ordy = 1'b1, sg = 1'b0, ir, ov;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;
  vedic_mul_pipe #(.W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a16), .b(b16),
    .sgn(sg), .out_valid(ov), .out_ready(ordy), .p(p16)
  );
  logic        iv_r [3], ordy_r [3], sg_r [3], ir_r [3], ov_r [3];
  logic [63:0] a_r [3], b_r [3];
  logic [15:0]  p8;
  logic [63:0]  p32;
  logic [127:0] p64;
  vedic_mul_pipe #(.W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_r[0]), .in_ready(ir_r[0]), .a(a_r[0][7:0]),
    .b(b_r[0][7:0]), .sgn(sg_r[0]), .out_valid(ov_r[0]), .out_ready(ordy_r[0]), .p(p8)
  );
  vedic_mul_pipe #(.W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_r[1]), .in_ready(ir_r[1]), .a(a_r[1][31:0]),
    .b(b_r[1][31:0]), .sgn(sg_r[1]), .out_valid(ov_r[1]), .out_ready(ordy_r[1]), .p(p32)
  );
  vedic_mul_pipe #(.W(64)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_r[2]), .in_ready(ir_r[2]), .a(a_r[2]),
    .b(b_r[2]), .sgn(sg_r[2]), .out_valid(ov_r[2]), .out_ready(ordy_r[2]), .p(p64)
  );
  initial for (int k = 0; k < 3; k++) begin
    iv_r[k] = 1'b0; ordy_r[k] = 1'b1; sg_r[k] = 1'b0; a_r[k] = '0; b_r[k] = '0;
  end

  function automatic logic [127:0] ref_mul(input int w, input logic [63:0] x, input logic [63:0] y, input logic s);
    logic signed [127:0] xs, ys, pr;
    xs = 128'(x);
    ys = 128'(y);
    if (s && x[w-1]) xs = xs - (128'(1) << w);
    if (s && y[w-1]) ys = ys - (128'(1) << w);
    pr = xs * ys;
    return pr & ((128'(1) << (2*w)) - 1);
  endfunction

  function automatic logic [127:0] getp(input int k);
    return k == 0 ? 128'(p8) : k == 1 ? 128'(p32) : p64;
  endfunction

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] m;
    int r;
    m = (w == 64) ? '1 : (64'(1) << w) - 1;
    r = $urandom_range(0, 7);
    return r == 0 ? 64'(0) : r == 1 ? m : r == 2 ? (64'(1) << (w-1)) : ({$urandom, $urandom} & m);
  endfunction

  task test_reset;
    @(negedge clk);
    total++;
    if (ov !== 1'b0 || ir !== 1'b1 || p16 !== 32'h0) begin
      $display("FAIL reset_state: out_valid=%b in_ready=%b p=%h, want 0 1 0", ov, ir, p16);
    end else passed++;
    rst_n = 1'b1;
  endtask

  task test_unsigned_max;
    @(negedge clk);
    ordy = 1'b1; iv = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; sg = 1'b0;
    @(negedge clk);
    iv = 1'b0;
    total++;
    if (ov !== 1'b0) $display("FAIL umax_early: out_valid=%b want 0", ov); else passed++;
    @(negedge clk);
    total++;
    if (ov !== 1'b1 || p16 !== 32'hFFFE0001) $display("FAIL umax: out_valid=%b p=%h want 1 fffe0001", ov, p16);
    else passed++;
    @(negedge clk);
    total++;
    if (ov !== 1'b0) $display("FAIL umax_drain: out_valid=%b want 0", ov); else passed++;
  endtask

  task test_signed;
    logic [15:0] ta [3], tb [3];
    logic [31:0] te [3];
    ta = '{16'h8000, 16'hFFFF, 16'h8000};
    tb = '{16'h8000, 16'h0002, 16'h7FFF};
    te = '{32'h40000000, 32'hFFFFFFFE, 32'hC0008000};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        total++;
        if (ov !== 1'b1 || p16 !== te[c-2]) $display("FAIL signed_%0d: out_valid=%b p=%h want 1 %h", c-2, ov, p16, te[c-2]);
        else passed++;
      end
      iv = c < 3; sg = 1'b1;
      if (c < 3) begin a16 = ta[c]; b16 = tb[c]; end
    end
    sg = 1'b0;
  endtask

  task test_back_to_back;
    logic [15:0] ta [8], tb [8];
    logic [31:0] te [8];
    ta = '{16'h0001, 16'h00FF, 16'h1234, 16'h0100, 16'hFFFF, 16'h8000, 16'h00FF, 16'h7FFF};
    tb = '{16'h0001, 16'h00FF, 16'h0010, 16'h0100, 16'h0001, 16'h0002, 16'h0101, 16'h7FFF};
    te = '{32'h1, 32'hFE01, 32'h12340, 32'h10000, 32'hFFFF, 32'h10000, 32'hFFFF, 32'h3FFF0001};
    ordy = 1'b1; sg = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        total++;
        if (ov !== 1'b1 || p16 !== te[c-2]) $display("FAIL b2b_%0d: out_valid=%b p=%h want 1 %h", c-2, ov, p16, te[c-2]);
        else passed++;
      end
      iv = c < 8;
      if (c < 8) begin a16 = ta[c]; b16 = tb[c]; end
      #1;
      total++;
      if (ir !== 1'b1) $display("FAIL b2b_ready_%0d: in_ready=%b want 1", c, ir); else passed++;
    end
    @(negedge clk);
    total++;
    if (ov !== 1'b0) $display("FAIL b2b_drain: out_valid=%b want 0", ov); else passed++;
  endtask

  task test_backpressure;
    logic [31:0] te [5];
    logic [31:0] held;
    logic stall, saw0;
    int idx, oc;
    te = '{32'd20, 32'd33, 32'd48, 32'd65, 32'd84};
    idx = 0; oc = 0; stall = 1'b0; saw0 = 1'b0; held = '0; sg = 1'b0;
    for (int c = 0; c < 40 && oc < 5; c++) begin
      @(negedge clk);
      if (stall) begin
        total++;
        if (ov !== 1'b1 || p16 !== held) $display("FAIL bp_hold_%0d: out_valid=%b p=%h want 1 %h", c, ov, p16, held);
        else passed++;
      end
      ordy = !(c >= 3 && c <= 5);
      iv = idx < 5; a16 = 16'(idx + 2); b16 = 16'(idx + 10);
      #1;
      if (!ir) saw0 = 1'b1;
      if (iv && ir) idx++;
      stall = ov && !ordy;
      held = p16;
      if (ov && ordy) begin
        total++;
        if (p16 !== te[oc]) $display("FAIL bp_out_%0d: p=%h want %h", oc, p16, te[oc]); else passed++;
        oc++;
      end
    end
    @(negedge clk);
    iv = 1'b0; ordy = 1'b1;
    total++;
    if (oc !== 5) $display("FAIL bp_count: got %0d results want 5", oc); else passed++;
    total++;
    if (saw0 !== 1'b1) $display("FAIL bp_stall_ready: in_ready never 0, want 0 while full"); else passed++;
    total++;
    if (ov !== 1'b0) $display("FAIL bp_dup: out_valid=%b want 0", ov); else passed++;
  endtask

  task test_reset_mid;
    @(negedge clk);
    ordy = 1'b0; iv = 1'b1; a16 = 16'd7; b16 = 16'd9; sg = 1'b0;
    @(negedge clk);
    a16 = 16'd11;
    @(negedge clk);
    iv = 1'b0;
    #1;
    total++;
    if (ov !== 1'b1 || ir !== 1'b0) $display("FAIL rst_full: out_valid=%b in_ready=%b want 1 0", ov, ir); else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (ov !== 1'b0 || ir !== 1'b1 || p16 !== 32'h0) $display("FAIL rst_async: out_valid=%b in_ready=%b p=%h want 0 1 0", ov, ir, p16);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1; ordy = 1'b1; iv = 1'b1; a16 = 16'd3; b16 = 16'd5;
    @(negedge clk);
    iv = 1'b0;
    total++;
    if (ov !== 1'b0) $display("FAIL rst_stale: out_valid=%b want 0", ov); else passed++;
    @(negedge clk);
    total++;
    if (ov !== 1'b1 || p16 !== 32'd15) $display("FAIL rst_after: out_valid=%b p=%h want 1 f", ov, p16); else passed++;
    @(negedge clk);
    total++;
    if (ov !== 1'b0) $display("FAIL rst_drain: out_valid=%b want 0", ov); else passed++;
  endtask

  task automatic run_rand(input int k, input int w);
    logic [127:0] q [$];
    logic [127:0] got, exp;
    int nin, nout, cyc;
    nin = 0; nout = 0; cyc = 0;
    while (nout < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      iv_r[k] = (nin < 10000) && ($urandom_range(0, 3) != 0);
      a_r[k] = rnd_op(w);
      b_r[k] = rnd_op(w);
      sg_r[k] = 1'($urandom_range(0, 1));
      ordy_r[k] = $urandom_range(0, 3) != 0;
      #1;
      if (iv_r[k] && ir_r[k]) begin
        q.push_back(ref_mul(w, a_r[k], b_r[k], sg_r[k]));
        nin++;
      end
      if (ov_r[k] && ordy_r[k]) begin
        got = getp(k);
        exp = q.size() > 0 ? q.pop_front() : '1;
        total++;
        if (got !== exp) $display("FAIL rand_w%0d_%0d: p=%h want %h", w, nout, got, exp); else passed++;
        nout++;
      end
    end
    iv_r[k] = 1'b0;
    total++;
    if (nout != 10000) $display("FAIL rand_w%0d_timeout: got %0d results want 10000", w, nout); else passed++;
  endtask

  task test_random;
    fork
      run_rand(0, 8);
      run_rand(1, 32);
      run_rand(2, 64);
    join
  endtask

  initial begin
    test_reset;
    test_unsigned_max;
    test_signed;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
